// File: rtl/v_bshift_rs.sv
// v_bshift_rs: streaming vector shifter, one WorkingRegs-lane chunk per cycle, per-vector runtime shift.
// Optional feature macro V_BSHIFT_RS_ROUND_EN: right shifts round half-up (default build truncates).
module v_bshift_rs #(
  parameter int unsigned InVecLength = 16,
  parameter int unsigned WorkingRegs = 4,
  parameter int unsigned NBits       = 8,
  parameter int unsigned MaxShift    = 7,
  localparam int unsigned SW         = $clog2(MaxShift + 1)
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic [SW-1:0]                            shift_amt,
  input  logic                                     shift_left,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [WorkingRegs-1:0][NBits-1:0] in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [WorkingRegs-1:0][NBits-1:0] out_data,
  output logic                                     out_last,
  output logic                                     out_sat,
  output logic                                     busy
);

  localparam int unsigned C  = (InVecLength + WorkingRegs - 1) / WorkingRegs;
  localparam int unsigned IW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned EW = NBits + MaxShift + 1;

  localparam logic signed [EW-1:0] SatMax = EW'((1 << (NBits - 1)) - 1);
  localparam logic signed [EW-1:0] SatMin = ~SatMax;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Out-of-range shift requests collapse to the largest legal shift.
  function automatic logic [SW-1:0] clamp_shift(input logic [SW-1:0] s);
    int unsigned s_wide;
    s_wide = 32'(s);
    return (s_wide > MaxShift) ? SW'(MaxShift) : s;
  endfunction

  // One lane: shift in a wide signed domain, then saturate; MSB of the result flags saturation.
  function automatic logic [NBits:0] shift_lane(input logic [NBits-1:0] x,
                                                input logic [SW-1:0]    s,
                                                input logic             left);
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] r;
    xe = EW'($signed(x));
`ifdef V_BSHIFT_RS_ROUND_EN
    rnd = (s == '0) ? '0 : (EW'(1) <<< (s - SW'(1)));
`else
    rnd = '0;
`endif
    sum = xe + rnd;
    r   = left ? (xe <<< s) : (sum >>> s);
    if (r > SatMax) return {1'b1, SatMax[NBits-1:0]};
    if (r < SatMin) return {1'b1, SatMin[NBits-1:0]};
    return {1'b0, r[NBits-1:0]};
  endfunction

  state_e                            state_q, state_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic [SW-1:0]                     lat_amt_q, lat_amt_d;
  logic                              lat_left_q, lat_left_d;
  logic                              xfer;
  logic                              last_chunk;
  logic [SW-1:0]                     eff_amt;
  logic                              eff_left;
  logic [WorkingRegs-1:0][NBits-1:0] lane_data;
  logic [WorkingRegs-1:0]            lane_sat;

  assign in_ready   = !out_valid || out_ready;
  assign xfer       = in_valid && in_ready;
  assign last_chunk = (idx_q == IW'(C - 1));
  assign busy       = (state_q == RUN) || out_valid;

  // Chunk 0 takes its shift from the live inputs; later chunks reuse the latched copy.
  assign eff_amt  = clamp_shift((state_q == IDLE) ? shift_amt : lat_amt_q);
  assign eff_left = (state_q == IDLE) ? shift_left : lat_left_q;

  for (genvar l = 0; l < WorkingRegs; l++) begin : g_lane
    logic [NBits:0] res;
    logic           pad;
    assign res          = shift_lane(in_data[l], eff_amt, eff_left);
    assign pad          = (32'(idx_q) * WorkingRegs + 32'(l)) >= InVecLength;
    assign lane_data[l] = pad ? '0 : res[NBits-1:0];
    assign lane_sat[l]  = !pad && res[NBits];
  end

  // Framing state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lat_amt_q  <= '0;
      lat_left_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_amt_q  <= lat_amt_d;
      lat_left_q <= lat_left_d;
    end
  end

  // Chunk counter / shift latch next state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_amt_d  = lat_amt_q;
    lat_left_d = lat_left_q;
    if (xfer) begin
      unique case (state_q)
        IDLE: begin
          lat_amt_d  = eff_amt;
          lat_left_d = eff_left;
          if (C > 1) begin
            state_d = RUN;
            idx_d   = IW'(1);
          end
        end
        RUN: begin
          if (last_chunk) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output stage: loads on transfer, holds while stalled, empties on a drain without refill.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= lane_data;
      out_last  <= last_chunk;
      out_sat   <= |lane_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
